// File: rtl/sw_token_source.sv
// Clocked token injector feeding a self-timed switch stage over a
// 4-phase return-to-zero handshake (SENDOUT/BROUT out, ACKIN back).
//
// Ports:
//   CLK, RESETN              clock, async active-low reset
//   TOKEN_VALID/BR/READY     upstream token push (push = VALID & READY)
//   SENDOUT, BROUT           registered request and branch bit to stage
//   ACKIN                    stage acknowledge, asynchronous
//   CLR_ERR                  pulse to leave the error state
//   BUSY, TIMEOUT            activity and sticky handshake-timeout flags
//   CNT_A, CNT_B             acknowledged tokens per branch (wrapping)
module sw_token_source #(
   parameter int FIFO_DEPTH  = 4,
   parameter int SETUP_CYC   = 1,
   parameter int TIMEOUT_CYC = 1024,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             TOKEN_VALID,
   input  logic             TOKEN_BR,
   output logic             TOKEN_READY,
   output logic             SENDOUT,
   output logic             BROUT,
   input  logic             ACKIN,
   input  logic             CLR_ERR,
   output logic             BUSY,
   output logic             TIMEOUT,
   output logic [CNT_W-1:0] CNT_A,
   output logic [CNT_W-1:0] CNT_B
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TMAX =
      (TIMEOUT_CYC > SETUP_CYC) ? TIMEOUT_CYC : SETUP_CYC;
   localparam int TW = $clog2(TMAX + 1);
   localparam bit TMO_EN = (TIMEOUT_CYC > 0);
   localparam logic [TW-1:0] SETUP_INIT = TW'(SETUP_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST =
      TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      REQ,
      RTZ,
      ERR
   } state_t;

   state_t          state, state_n;
   logic [TW-1:0]   tmr, tmr_n;
   logic            send_n, br_n, to_n;
   logic            pop, inc_a, inc_b;
   logic            tmo_hit;

   logic            ack_m, ack_s;

   logic            mem [FIFO_DEPTH];
   logic [AW:0]     wptr, rptr;
   logic            empty, full, push, head;

   // ACKIN comes from a self-timed domain; only ack_s feeds decisions.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         ack_m <= 1'b0;
         ack_s <= 1'b0;
      end else begin
         ack_m <= ACKIN;
         ack_s <= ack_m;
      end
   end

   // Token buffer: extra pointer bit separates full from empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push  = TOKEN_VALID && !full;
   assign head  = mem[rptr[AW-1:0]];

   always_ff @(posedge CLK) begin
      if (push) mem[wptr[AW-1:0]] <= TOKEN_BR;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // State register; SENDOUT/BROUT are flops so the stage sees no glitches.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state   <= IDLE;
         tmr     <= '0;
         SENDOUT <= 1'b0;
         BROUT   <= 1'b0;
         TIMEOUT <= 1'b0;
         CNT_A   <= '0;
         CNT_B   <= '0;
      end else begin
         state   <= state_n;
         tmr     <= tmr_n;
         SENDOUT <= send_n;
         BROUT   <= br_n;
         TIMEOUT <= to_n;
         if (inc_a) CNT_A <= CNT_A + 1'b1;
         if (inc_b) CNT_B <= CNT_B + 1'b1;
      end
   end

   assign tmo_hit = TMO_EN && (tmr == TMO_LAST);

   // Next state. Acknowledge wins over timeout in the same cycle.
   always_comb begin
      state_n = state;
      tmr_n   = tmr;
      send_n  = SENDOUT;
      br_n    = BROUT;
      to_n    = TIMEOUT;
      pop     = 1'b0;
      inc_a   = 1'b0;
      inc_b   = 1'b0;
      unique case (state)
         IDLE: begin
            send_n = 1'b0;
            if (!empty && !ack_s) begin
               br_n    = head;
               pop     = 1'b1;
               tmr_n   = SETUP_INIT;
               state_n = SETUP;
            end
         end
         SETUP: begin
            if (tmr == '0) begin
               send_n  = 1'b1;
               tmr_n   = '0;
               state_n = REQ;
            end else begin
               tmr_n = tmr - 1'b1;
            end
         end
         REQ: begin
            if (ack_s) begin
               send_n  = 1'b0;
               inc_a   = !BROUT;
               inc_b   = BROUT;
               tmr_n   = '0;
               state_n = RTZ;
            end else if (tmo_hit) begin
               send_n  = 1'b0;
               to_n    = 1'b1;
               state_n = ERR;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         RTZ: begin
            send_n = 1'b0;
            if (!ack_s) begin
               state_n = IDLE;
            end else if (tmo_hit) begin
               to_n    = 1'b1;
               state_n = ERR;
            end else begin
               tmr_n = tmr + 1'b1;
            end
         end
         ERR: begin
            send_n = 1'b0;
            // Leaving with ack high would start the next token mid-phase.
            if (CLR_ERR && !ack_s) begin
               to_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      TOKEN_READY = !full;
      BUSY        = (state != IDLE) || !empty;
   end

endmodule

// File: tb/tb_sw_token_source.sv
// Self-checking bench for sw_token_source: vector table, directed
// corner sequences and randomized traffic against a token-order model.
module tb_sw_token_source;

   logic       CLK = 1'b0;
   logic       RESETN;
   logic       TOKEN_VALID;
   logic       TOKEN_BR;
   logic       TOKEN_READY;
   logic       SENDOUT;
   logic       BROUT;
   logic       ACKIN = 1'b0;
   logic       CLR_ERR;
   logic       BUSY;
   logic       TIMEOUT;
   logic [3:0] CNT_A;
   logic [3:0] CNT_B;

   sw_token_source #(
      .FIFO_DEPTH (4),
      .SETUP_CYC  (1),
      .TIMEOUT_CYC(8),
      .CNT_W      (4)
   ) dut (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .TOKEN_VALID(TOKEN_VALID),
      .TOKEN_BR   (TOKEN_BR),
      .TOKEN_READY(TOKEN_READY),
      .SENDOUT    (SENDOUT),
      .BROUT      (BROUT),
      .ACKIN      (ACKIN),
      .CLR_ERR    (CLR_ERR),
      .BUSY       (BUSY),
      .TIMEOUT    (TIMEOUT),
      .CNT_A      (CNT_A),
      .CNT_B      (CNT_B)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, got, exp);
      end
   endtask

   // Stage model: ACKIN either forced or SENDOUT delayed ack_dly cycles.
   logic [7:0] hist = 8'h00;
   int         ack_dly = 3;
   bit         ack_follow = 1'b0;
   logic       ack_force = 1'b0;

   always begin
      @(posedge CLK);
      #1;
      hist  = ack_follow ? {hist[6:0], SENDOUT} : 8'h00;
      ACKIN = ack_follow ? hist[ack_dly] : ack_force;
   end

   // Records BROUT at every request and checks it holds while requested.
   logic sent_q[$];
   logic prev_so = 1'b0;
   logic prev_br = 1'b0;

   always @(negedge CLK) begin
      if (!RESETN) begin
         prev_so = 1'b0;
      end else begin
         if (SENDOUT && !prev_so) sent_q.push_back(BROUT);
         if (SENDOUT && prev_so) chk("brout_stable", BROUT, prev_br);
         prev_so = SENDOUT;
         prev_br = BROUT;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_reset();
      RESETN      = 1'b0;
      TOKEN_VALID = 1'b0;
      TOKEN_BR    = 1'b0;
      CLR_ERR     = 1'b0;
      step(2);
      RESETN = 1'b1;
      step(1);
   endtask

   task automatic offer(input logic br, input int lim);
      int i;
      TOKEN_VALID = 1'b1;
      TOKEN_BR    = br;
      i = 0;
      while (!TOKEN_READY && i < lim) begin
         step();
         i++;
      end
      if (!TOKEN_READY) chk("offer_ready_wait", TOKEN_READY, 1);
      step();
      TOKEN_VALID = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int i;
      i = 0;
      while (BUSY && i < lim) begin
         step();
         i++;
      end
      chk("drain_busy", BUSY, 0);
   endtask

   typedef struct {
      logic br;
      logic exp_ready;
   } vec_t;

   vec_t tbl[5];
   logic acc_q[$];
   int   cnt_a_m, cnt_b_m;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b1, 1'b1};
      tbl[1] = '{1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b1};
      tbl[4] = '{1'b0, 1'b0};

      RESETN      = 1'b0;
      TOKEN_VALID = 1'b0;
      TOKEN_BR    = 1'b0;
      CLR_ERR     = 1'b0;
      #12;
      chk("rst_sendout", SENDOUT, 0);
      chk("rst_brout", BROUT, 0);
      chk("rst_timeout", TIMEOUT, 0);
      chk("rst_cnt_a", CNT_A, 0);
      chk("rst_cnt_b", CNT_B, 0);
      chk("rst_ready", TOKEN_READY, 1);
      chk("rst_busy", BUSY, 0);

      // Single token, ack follows SENDOUT by 3 cycles.
      ack_follow = 1'b1;
      ack_dly    = 3;
      do_reset();
      step(2);
      TOKEN_VALID = 1'b1;
      TOKEN_BR    = 1'b1;
      step();
      TOKEN_VALID = 1'b0;
      chk("t2_brout_e1", BROUT, 0);
      step();
      chk("t2_brout_e2", BROUT, 1);
      chk("t2_sendout_e2", SENDOUT, 0);
      step();
      chk("t2_sendout_e3", SENDOUT, 1);
      wait_idle(40);
      chk("t2_cnt_b", CNT_B, 1);
      chk("t2_cnt_a", CNT_A, 0);

      // Reset in the middle of a request.
      TOKEN_VALID = 1'b1;
      TOKEN_BR    = 1'b0;
      step();
      TOKEN_VALID = 1'b0;
      for (int i = 0; i < 20 && !SENDOUT; i++) step();
      chk("t1_sendout_high", SENDOUT, 1);
      #2;
      RESETN = 1'b0;
      #1;
      chk("t1_sendout_async", SENDOUT, 0);
      chk("t1_cnt_a", CNT_A, 0);
      chk("t1_cnt_b", CNT_B, 0);
      step();
      RESETN = 1'b1;
      step();
      chk("t1_ready", TOKEN_READY, 1);
      chk("t1_busy", BUSY, 0);

      // Ordering and full buffer with ack stuck high.
      ack_follow = 1'b0;
      ack_force  = 1'b1;
      step(4);
      sent_q.delete();
      for (int i = 0; i < 5; i++) begin
         TOKEN_VALID = 1'b1;
         TOKEN_BR    = tbl[i].br;
         chk($sformatf("t3_ready%0d", i), TOKEN_READY, tbl[i].exp_ready);
         step();
      end
      ack_follow = 1'b1;
      offer(tbl[4].br, 60);
      wait_idle(200);
      chk("t3_sent_count", sent_q.size(), 5);
      for (int i = 0; i < 5 && i < sent_q.size(); i++)
         chk($sformatf("t3_order%0d", i), sent_q[i], tbl[i].br);
      chk("t3_cnt_a", CNT_A, 2);
      chk("t3_cnt_b", CNT_B, 3);

      // Handshake timeout with ack held low.
      ack_follow = 1'b0;
      ack_force  = 1'b0;
      do_reset();
      step(4);
      TOKEN_VALID = 1'b1;
      TOKEN_BR    = 1'b1;
      step();
      TOKEN_VALID = 1'b0;
      step(2);
      chk("t4_sendout_rise", SENDOUT, 1);
      step(7);
      chk("t4_sendout_last", SENDOUT, 1);
      chk("t4_timeout_early", TIMEOUT, 0);
      step();
      chk("t4_sendout_drop", SENDOUT, 0);
      chk("t4_timeout_set", TIMEOUT, 1);
      offer(1'b0, 10);
      step(3);
      chk("t4_err_busy", BUSY, 1);
      chk("t4_err_sendout", SENDOUT, 0);
      chk("t4_err_sticky", TIMEOUT, 1);
      CLR_ERR = 1'b1;
      step();
      CLR_ERR = 1'b0;
      chk("t4_cleared", TIMEOUT, 0);
      ack_follow = 1'b1;
      wait_idle(60);
      chk("t4_cnt_a", CNT_A, 1);
      chk("t4_cnt_b", CNT_B, 0);

      // Clear while ack is stuck high must be ignored.
      ack_follow = 1'b0;
      ack_force  = 1'b0;
      step(2);
      offer(1'b1, 10);
      for (int i = 0; i < 30 && !TIMEOUT; i++) step();
      chk("t5_timeout", TIMEOUT, 1);
      ack_force = 1'b1;
      step(4);
      CLR_ERR = 1'b1;
      step();
      CLR_ERR = 1'b0;
      step();
      chk("t5_ignored_to", TIMEOUT, 1);
      chk("t5_ignored_busy", BUSY, 1);
      ack_force = 1'b0;
      step(4);
      CLR_ERR = 1'b1;
      step();
      CLR_ERR = 1'b0;
      chk("t5_cleared", TIMEOUT, 0);
      chk("t5_idle", BUSY, 0);
      chk("t5_cnt_b", CNT_B, 0);

      // Counter wrap: 17 branch-A tokens on a 4-bit counter.
      do_reset();
      ack_dly    = 1;
      ack_follow = 1'b1;
      sent_q.delete();
      for (int i = 0; i < 17; i++) offer(1'b0, 40);
      wait_idle(300);
      chk("t6_cnt_a", CNT_A, 1);
      chk("t6_cnt_b", CNT_B, 0);
      chk("t6_sent", sent_q.size(), 17);

      // Random traffic against the order/count model.
      for (int r = 0; r < 3; r++) begin
         ack_follow = 1'b0;
         do_reset();
         ack_dly    = int'($urandom_range(1, 4));
         ack_follow = 1'b1;
         sent_q.delete();
         acc_q.delete();
         cnt_a_m = 0;
         cnt_b_m = 0;
         for (int c = 0; c < 80; c++) begin
            TOKEN_VALID = 1'($urandom_range(0, 1));
            TOKEN_BR    = 1'($urandom_range(0, 1));
            if (int'(acc_q.size()) - int'(sent_q.size()) < 4)
               chk("rnd_ready", TOKEN_READY, 1);
            if (TOKEN_VALID && TOKEN_READY) begin
               acc_q.push_back(TOKEN_BR);
               if (TOKEN_BR) cnt_b_m++;
               else cnt_a_m++;
            end
            step();
         end
         TOKEN_VALID = 1'b0;
         wait_idle(400);
         chk("rnd_count", sent_q.size(), acc_q.size());
         for (int i = 0; i < acc_q.size() && i < sent_q.size(); i++)
            chk($sformatf("rnd_order%0d", i), sent_q[i], acc_q[i]);
         chk("rnd_cnt_a", CNT_A, 4'(cnt_a_m));
         chk("rnd_cnt_b", CNT_B, 4'(cnt_b_m));
         chk("rnd_timeout", TIMEOUT, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
